// File: rtl/muldiv_seq.sv
// muldiv_seq: 34-cycle MUL/DIVU/REMU sequencer that borrows the shared ALU one step per clock.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] funct_q, funct_d;
  // acc doubles as rem, x as mcand/quo, y as mplier/dvsr
  logic [31:0] acc_q, acc_d, x_q, x_d, y_q, y_d, result_q, result_d;
  logic run, is_div, ge;
  logic [31:0] sh;
  assign run = state_q == RUN;
  assign is_div = funct_q == 2'b01 || funct_q == 2'b10;
  assign sh = {acc_q[30:0], x_q[31]};
  assign ge = acc_q[31] | (sh >= y_q);
  assign alu_op = run && is_div ? ALU_SUB : ALU_ADD;
  assign alu_op1 = !run ? '0 : is_div ? sh : acc_q;
  assign alu_op2 = !run ? '0 : is_div ? y_q : (y_q[0] ? x_q : '0);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    funct_d = funct_q;
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    result_d = result_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      cnt_d = '0;
      funct_d = funct;
      acc_d = '0;
      x_d = a;
      y_d = b;
    end else if (run) begin
      acc_d = is_div ? (ge ? alu_result : sh) : alu_result;
      x_d = is_div ? {x_q[30:0], ge} : x_q << 1;
      y_d = is_div ? y_q : y_q >> 1;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = DONE;
        result_d = funct_q == 2'b01 ? x_d : acc_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      funct_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      funct_q <= funct_d;
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random MUL/DIVU/REMU runs against an arithmetic reference model.
module tb_muldiv_seq;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [1:0] funct = 0;
  logic [31:0] a = 0, b = 0, result, alu_op1, alu_op2, alu_result;
  logic [3:0] alu_op;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign alu_result = alu_op == 4'b0110 ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_result(alu_result)
  );
  function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [31:0] x, y);
    if (f == 2'd1) return y == 0 ? 32'hFFFFFFFF : x / y;
    if (f == 2'd2) return y == 0 ? x : x % y;
    return x * y;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [31:0] exp_res);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'h2);
    chk({tag, "_alu_op1"}, alu_op1, 32'd0);
    chk({tag, "_alu_op2"}, alu_op2, 32'd0);
  endtask
  // entered #1 after an edge (cycle 0); leaves #1 after the edge starting cycle 34
  task automatic run_op(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input int p1 = 0, input int p2 = 0);
    logic [31:0] e;
    logic [3:0] op_e;
    e = ref_op(f, av, bv);
    op_e = (f == 2'd1 || f == 2'd2) ? 4'b0110 : 4'b0010;
    start = 1; funct = f; a = av; b = bv;
    @(posedge clk); #1;
    for (int c = 1; c <= 33; c++) begin
      start = (c == p1 || c == p2);
      a = $urandom; b = $urandom; funct = 2'($urandom);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(c == 33));
      if (c == 33) chk("result", result, e);
      else chk("alu_op_run", 32'(alu_op), 32'(op_e));
      @(posedge clk); #1;
    end
    start = 0;
    chk_idle("after", e);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset", 32'd0);
    rst = 0;
    run_op(2'd0, 32'd7, 32'd6);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd0, 32'h80000000, 32'd2);
    run_op(2'd1, 32'd100, 32'd7);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd1, 32'hFFFFFFFF, 32'd1);
    run_op(2'd2, 32'hFFFFFFFF, 32'd1);
    run_op(2'd1, 32'hFFFFFFFF, 32'h80000001);
    run_op(2'd2, 32'hFFFFFFFF, 32'h80000001);
    run_op(2'd1, 32'h12345678, 32'd0);
    run_op(2'd2, 32'h12345678, 32'd0);
    run_op(2'd3, 32'd9, 32'd11);
    run_op(2'd0, 32'd9, 32'd11, 5, 33);
    run_op(2'd2, 32'd1000, 32'd33);
    start = 1; funct = 2'd1; a = 32'hDEADBEEF; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 10; c++) begin
      rst = (c == 10);
      @(posedge clk); #1;
    end
    rst = 0;
    chk_idle("rst_mid", 32'd0);
    for (int c = 11; c <= 33; c++) begin
      chk("rst_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    run_op(2'd0, 32'd3, 32'd5);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] f;
      logic [31:0] av, bv;
      f = 2'($urandom_range(0, 3));
      av = $urandom;
      bv = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(f, av, bv);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer that computes RV32M MUL, DIVU and REMU by driving the shared 32-bit ALU one step per clock. It sits beside the ALU in the execute stage. While the sequencer runs, it owns the ALU operand and opcode inputs through a mux selected by `busy`, and reads back the ALU result combinationally. Latency is fixed and data-independent.

## Interface
- `ALU_ADD`, 4'b0010: ALU opcode issued for multiply steps and when idle.
- `ALU_SUB`, 4'b0110: ALU opcode issued for divide steps.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new operation; sampled only in IDLE.
- `funct` input 2: 00 MUL, 01 DIVU, 10 REMU, 11 reserved (executes as MUL).
- `a` input 32: multiplicand or dividend; captured on accepted `start`.
- `b` input 32: multiplier or divisor; captured on accepted `start`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output 32: registered result, held until the next accepted `start`.
- `alu_op1` output 32: ALU operand 1.
- `alu_op2` output 32: ALU operand 2.
- `alu_op` output 4: ALU opcode.
- `alu_result` input 32: ALU result, fed back combinationally in the same cycle.

## Operation
- **States:** IDLE, RUN, DONE. A 5-bit step counter `cnt` counts through RUN.
- **IDLE, `start`=1:**
  - Latch `funct`.
  - Multiply: `acc`=0, `mcand`=`a`, `mplier`=`b`.
  - Divide: `rem`=0, `quo`=`a`, `dvsr`=`b`.
  - Set `cnt`=0 and go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, multiply step:**
  - Drive `alu_op`=ADD, `alu_op1`=`acc`, `alu_op2`=`mplier[0]` ? `mcand` : 0.
  - Update `acc`<=`alu_result`, `mcand`<=`mcand`<<1, `mplier`<=`mplier`>>1.
- **RUN, divide step (restoring):**
  - `msb`=`rem[31]`; `sh`={`rem[30:0]`,`quo[31]`}.
  - `ge`=`msb` | (`sh` >= `dvsr`, unsigned compare done internally).
  - Drive `alu_op`=SUB, `alu_op1`=`sh`, `alu_op2`=`dvsr`.
  - Update `rem`<= `ge` ? `alu_result` : `sh`, and `quo`<={`quo[30:0]`,`ge`}.
- **RUN exit:** after the step with `cnt`=31, go to DONE and load `result`:
  - `acc` for MUL and reserved.
  - `quo` for DIVU.
  - `rem` for REMU.
- **DONE:** `done`=1; unconditionally return to IDLE on the next edge.
- **Outside RUN:** `alu_op`=ADD, `alu_op1`=0, `alu_op2`=0.
- **Arithmetic:** all operations are modulo 2^32, and MUL returns the low 32 bits.
- **Divide by zero:** falls out of the algorithm with no special case. DIVU returns 0xFFFFFFFF and REMU returns `a`, matching RISC-V.
- **`start` while busy:** `start` in RUN or DONE is ignored; there is no queueing.
- **Inputs after capture:** changes to `a`, `b` or `funct` after capture have no effect.
- **`rst` at any time, including mid-RUN:**
  - Next state is IDLE.
  - `busy`=0, `done`=0, `result`=0, `cnt`=0; all datapath registers cleared.
  - No `done` pulse is produced for the aborted operation.

## Timing
- **Reset values:** `busy`=0, `done`=0, `result`=0, `alu_op`=ADD, `alu_op1`=0, `alu_op2`=0.
- **Latency:** with `start` high in IDLE at cycle 0:
  - `busy` is high from cycle 1.
  - RUN occupies cycles 1–32.
  - `done`=1 and `result` is valid in cycle 33.
  - Cycle 34 is IDLE with `busy`=0.
- **Back-to-back:** the earliest next accepted `start` is cycle 34, giving a throughput of one operation per 34 cycles.
- **ALU path:** the ALU is combinational. The `alu_result` sampled at an edge corresponds to the operands driven during that same cycle.
- **Output timing:** `busy`, `done` and `result` are registered. `alu_*` outputs are combinational from state registers only, never from `start`, `a` or `b`.

## Test plan
- **MUL:** `a`=7, `b`=6, `start` at cycle 0 → `done`=1 at cycle 33 with `result`=42; `busy` high in cycles 1–33.
- **MUL wrap:** `a`=`b`=0xFFFFFFFF → `result`=0x00000001. Then `a`=0x80000000, `b`=2 → `result`=0.
- **DIVU/REMU:**
  - 100/7 → DIVU gives 14, REMU gives 2.
  - `a`=0xFFFFFFFF, `b`=1 → DIVU gives 0xFFFFFFFF, REMU gives 0.
  - `a`=0xFFFFFFFF, `b`=0x80000001 → DIVU gives 1, REMU gives 0x7FFFFFFE (exercises the `msb` carry path).
- **Divide by zero:** `a`=0x12345678, `b`=0 → DIVU gives 0xFFFFFFFF, REMU gives 0x12345678; latency is still 33 cycles.
- **Ignored start:**
  - `start` pulsed in cycles 5 and 33 with different operands → the first operation completes unchanged; no second operation begins.
  - `start` in cycle 34 is accepted.
- **Reset mid-run:** `rst` in cycle 10 of a DIVU → cycle 11 shows `busy`=0, `done`=0, `result`=0; no `done` pulse in cycle 33. A new MUL 3*5 afterwards returns 15 after 33 cycles.
